// File: rtl/definitions_pkg.sv
// Shared image-pipeline definitions: frame geometry, pixel/window types and the
// 3x3 kernels whose element order (k = 0..8, row-major) the window generator follows.
package definitions_pkg;

  localparam int IMAGE_WIDTH = 512;
  localparam int WIN_K       = 3;
  localparam int WIN_N       = WIN_K * WIN_K;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [0:8] window_t;

  // Kernel coefficients, element k multiplies window element k.
  localparam int GAUSS_K   [0:8] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  localparam int SOBEL_X_K [0:8] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int SOBEL_Y_K [0:8] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  // Rows seen in the current frame; saturates once two earlier rows are buffered.
  typedef enum logic [1:0] {
    ROW_0    = 2'd0,
    ROW_1    = 2'd1,
    ROW_FULL = 2'd2
  } row_state_t;

  function automatic row_state_t row_advance(input row_state_t r);
    return (r == ROW_0) ? ROW_1 : ROW_FULL;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port row store: asynchronous read and synchronous write at the same
// address, so a read in the accepting cycle returns the previous row's pixel.
module line_buffer #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; stale rows are never emitted because windows
  // are gated until two fresh rows of the current frame have been written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register
// emit one window per interior pixel. WIN3_FRAME_MARKERS_EN adds out_sof/out_eol.
module window_gen_3x3 #(
  parameter int IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH,
  parameter int PIX_W       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_sof,
  input  logic [PIX_W-1:0]                       in_pixel,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [definitions_pkg::WIN_N*PIX_W-1:0] out_window
`ifdef WIN3_FRAME_MARKERS_EN
  ,
  output logic                                   out_sof,
  output logic                                   out_eol
`endif
);

  import definitions_pkg::*;

  localparam int             CW       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [CW-1:0]  COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0]  COL_TWO  = CW'(2);

  logic [CW-1:0]      col_q, col_eff, col_nxt;
  row_state_t         row_q, row_eff;
  logic               accept, emit, wrap;
  logic [PIX_W-1:0]   lb1_rd, lb0_rd;
  logic [PIX_W-1:0]   sr_q   [WIN_K][WIN_K];
  logic [PIX_W-1:0]   sr_nxt [WIN_K][WIN_K];
  logic [WIN_N*PIX_W-1:0] win_flat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  assign col_eff  = in_sof ? '0 : col_q;
  assign row_eff  = in_sof ? ROW_0 : row_q;
  assign wrap     = (col_eff == COL_LAST);
  assign col_nxt  = wrap ? '0 : col_eff + CW'(1);
  assign emit     = accept && (row_eff == ROW_FULL) && (col_eff >= COL_TWO);

  // lb1 holds row r-1; its old contents cascade into lb0 (row r-2).
  line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (in_pixel),
    .rdata (lb1_rd)
  );

  line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  // NOTE: every variable driven here gets a full default first, so no latch
  // can be inferred even if a later branch is added.
  always_comb begin
    sr_nxt = sr_q;
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K - 1; c++) begin
        sr_nxt[r][c] = sr_q[r][c+1];
      end
    end
    sr_nxt[0][WIN_K-1] = lb0_rd;
    sr_nxt[1][WIN_K-1] = lb1_rd;
    sr_nxt[2][WIN_K-1] = in_pixel;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K; c++) begin
        win_flat[PIX_W*(r*WIN_K + c) +: PIX_W] = sr_nxt[r][c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, matching the read-before-write buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= ROW_0;
      out_valid  <= 1'b0;
      out_window <= '0;
      for (int r = 0; r < WIN_K; r++) begin
        for (int c = 0; c < WIN_K; c++) begin
          sr_q[r][c] <= '0;
        end
      end
    end else begin
      if (accept) begin
        col_q <= col_nxt;
        row_q <= wrap ? row_advance(row_eff) : row_eff;
        sr_q  <= sr_nxt;
      end
      // Load wins over drain, giving back-to-back windows with no bubble.
      if (emit) begin
        out_valid  <= 1'b1;
        out_window <= win_flat;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef WIN3_FRAME_MARKERS_EN
  // The row counter saturates, so a separate flag tracks the frame's first window.
  logic first_win_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_win_q <= 1'b1;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
    end else begin
      if (accept && in_sof) first_win_q <= 1'b1;
      else if (emit)        first_win_q <= 1'b0;
      if (emit) begin
        out_sof <= first_win_q;
        out_eol <= wrap;
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 (IMAGE_WIDTH=8): directed vector table,
// stall/SOF/reset sequences and a randomized run against a frame-array model.
module tb_window_gen_3x3;

  localparam int W  = 8;
  localparam int PW = 8;
  localparam int WB = 9 * PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid, out_ready;
  logic [WB-1:0] out_window;
`ifdef WIN3_FRAME_MARKERS_EN
  logic          out_sof, out_eol;
`endif

  always #5 clk = ~clk;

  window_gen_3x3 #(.IMAGE_WIDTH(W), .PIX_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window)
`ifdef WIN3_FRAME_MARKERS_EN
    ,
    .out_sof    (out_sof),
    .out_eol    (out_eol)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model: frame stored as a 2-D array ----------------
  typedef struct {
    logic [WB-1:0] win;
    logic          sof;
    logic          eol;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] img [16][W];
  int            mx = 0, my = 0;
  int            n_win = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mx = 0;
      my = 0;
    end else begin
      if (out_valid && out_ready) begin
        exp_t e;
        n_win++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got window %h expected none", out_window);
        end else begin
          e = exp_q.pop_front();
          check("sb_window", out_window, e.win);
`ifdef WIN3_FRAME_MARKERS_EN
          check_int("sb_sof", int'(out_sof), int'(e.sof));
          check_int("sb_eol", int'(out_eol), int'(e.eol));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        if (in_sof) begin
          mx = 0;
          my = 0;
        end
        img[my % 16][mx] = in_pixel;
        if (my >= 2 && mx >= 2) begin
          e.win = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.win[PW*(i*3 + j) +: PW] = img[(my - 2 + i) % 16][mx - 2 + j];
          e.sof = (my == 2 && mx == 2);
          e.eol = (mx == W - 1);
          exp_q.push_back(e);
        end
        mx++;
        if (mx == W) begin
          mx = 0;
          my++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] pix(input int base, input int r, input int c);
    return PW'((base + r * W + c) & 255);
  endfunction

  function automatic logic [WB-1:0] pack9(input int v [9]);
    logic [WB-1:0] res;
    res = '0;
    for (int k = 0; k < 9; k++) res[PW*k +: PW] = PW'(v[k]);
    return res;
  endfunction

  // Window whose bottom-right pixel is (r,c) of a frame filled by pix(base,...).
  function automatic logic [WB-1:0] grid(input int base, input int r, input int c);
    logic [WB-1:0] res;
    res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res[PW*(i*3 + j) +: PW] = pix(base, r - 2 + i, c - 2 + j);
    return res;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [PW-1:0] p);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            pix;
    logic [WB-1:0] win;
  } vec_t;

  vec_t          vecs [6];
  logic [PW-1:0] rp   [80];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n0, vi, idx, cyc;
    logic          acc;
    logic [WB-1:0] held;

    vecs[0].pix = 18;
    vecs[0].win = pack9('{0, 1, 2, 8, 9, 10, 16, 17, 18});
    for (int j = 1; j < 5; j++) begin
      vecs[j].pix = 18 + j;
      vecs[j].win = grid(0, 2, 2 + j);
    end
    vecs[5].pix = 23;
    vecs[5].win = pack9('{5, 6, 7, 13, 14, 15, 21, 22, 23});

    // Reset state
    do_reset();
    check_int("rst_out_valid", int'(out_valid), 0);
    check("rst_out_window", out_window, '0);
    check_int("rst_in_ready", int'(in_ready), 1);

    // First 24 pixels: windows only from pixel 18 onward
    n0 = n_win;
    vi = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, i == 0, PW'(i));
      check_int("t1_valid", int'(out_valid), (i >= 18) ? 1 : 0);
      if (vi < 6 && i == vecs[vi].pix) begin
        check("t1_window", out_window, vecs[vi].win);
        vi++;
      end
    end
    drive(1'b0, 1'b0, '0);
    check_int("t1_count", n_win - n0, 6);

    // Back-pressure: window pending, out_ready low for 5 cycles
    n0 = n_win;
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, pix(0, 3, c));
    held      = grid(0, 3, 2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = pix(0, 3, 3);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_int("t2_in_ready", int'(in_ready), 0);
      check_int("t2_valid", int'(out_valid), 1);
      check("t2_hold", out_window, held);
    end
    out_ready = 1'b1;
    for (int c = 3; c < W; c++) drive(1'b1, 1'b0, pix(0, 3, c));
    drive(1'b0, 1'b0, '0);
    check_int("t2_count", n_win - n0, 6);
    check_int("t2_pending", exp_q.size(), 0);

    // SOF at (2,4): no window until the new frame's (2,2)
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W && !(r == 2 && c == 4); c++)
        drive(1'b1, r == 0 && c == 0, pix(0, r, c));
    drive(1'b0, 1'b0, '0);
    n0 = n_win;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b1, r == 0 && c == 0, pix(128, r, c));
        if (r < 2 || c < 2) begin
          check_int("t3_quiet", int'(out_valid), 0);
        end
        if (r == 2 && c == 2) begin
          check_int("t3_gap", n_win - n0, 0);
          check_int("t3_valid", int'(out_valid), 1);
          check("t3_first", out_window, pack9('{128, 129, 130, 136, 137, 138, 144, 145, 146}));
        end
      end
    end
    drive(1'b0, 1'b0, '0);
    check_int("t3_pending", exp_q.size(), 0);

    // Asynchronous reset mid row 3, then a clean frame without SOF
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W && !(r == 3 && c == 4); c++)
        drive(1'b1, r == 0 && c == 0, pix(64, r, c));
    check_int("t4_pre_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_int("t4_rst_valid", int'(out_valid), 0);
    check("t4_rst_window", out_window, '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    n0 = n_win;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b1, 1'b0, pix(64, r, c));
        if (r == 2 && c == 2) check("t4_first", out_window, grid(64, 2, 2));
      end
    end
    drive(1'b0, 1'b0, '0);
    check_int("t4_count", n_win - n0, 12);
    check_int("t4_pending", exp_q.size(), 0);

    // Random valid/ready over a 10-row frame of random pixels
    for (int k = 0; k < 80; k++) rp[k] = PW'($urandom);
    n0  = n_win;
    idx = 0;
    cyc = 0;
    while (idx < 80 && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sof    = (idx == 0);
      in_pixel  = rp[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    if (idx < 80) begin
      checks++;
      failures++;
      $display("FAIL t5_timeout: got %0d pixels accepted expected 80", idx);
    end
    out_ready = 1'b1;
    repeat (3) drive(1'b0, 1'b0, '0);
    check_int("t5_count", n_win - n0, 48);
    check_int("t5_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3×3 neighbourhood generator that sits directly upstream of the Gaussian/Sobel convolution stage. It accepts a raster-order 8-bit pixel stream, for example from the UART receive path. Two line buffers store the previous image rows, and the block emits one complete 3×3 window per interior pixel, ordered to match kernel index 0..8 in `definitions_pkg`. Border pixels produce no window; the output is (W−2)×(H−2) windows per frame.

## Interface
- `IMAGE_WIDTH`, default `definitions_pkg::IMAGE_WIDTH` (512): pixels per row; must be ≥ 3.
- `PIX_W`, default 8: pixel width.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input pixel present.
- `in_ready`  out  1  block can accept a pixel.
- `in_sof`  in  1  qualifies the accepted pixel as row 0, column 0 of a new frame.
- `in_pixel`  in  PIX_W  pixel value.
- `out_valid`  out  1  window present.
- `out_ready`  in  1  downstream accepts the window.
- `out_window`  out  9×PIX_W  `out_window[PIX_W*k +: PIX_W]` is element k. k=0 is top-left (oldest row, oldest column) and k=8 is bottom-right (newest pixel), in row-major order.

## Operation
- Accept: `in_valid && in_ready`. `in_ready = !out_valid || out_ready`. `in_ready` is combinational and does not depend on `in_valid`.
- State:
  - `col` counts 0..IMAGE_WIDTH−1 and wraps to 0 at end of row.
  - `row` is a 2-bit counter that saturates at 2.
  - `lb1` holds row r−1 and `lb0` holds row r−2, each with depth IMAGE_WIDTH and read at address `col`.
  - A 3×3 shift register holds three columns.
- On accept, in one cycle:
  - Read `lb1[col]` (a) and `lb0[col]` (b).
  - Write `lb0[col] ← a` and `lb1[col] ← in_pixel`.
  - Shift the column {b, a, in_pixel} into the right of the window; the leftmost column drops out.
  - Advance `col`. At wrap, increment `row` with saturation.
- `in_sof` on an accepted pixel forces that pixel to be (0,0): `col` and `row` are treated as 0 for this pixel, so the next state is col=1, row=0. Counters restart even mid-row or mid-frame. Line-buffer contents are not cleared; this is safe because output is gated.
- Window emitted (registered) when the accepted pixel has row==2 and col≥2, using pre-increment values.
- Output register:
  - Loads on a qualifying accept.
  - `out_valid` clears on `out_ready` when there is no qualifying accept in the same cycle.
  - Simultaneous drain and load: the new window replaces the old one with no bubble.
- Reset values:
  - `out_valid`=0, `out_window`=0, `col`=0, `row`=0, shift registers 0.
  - Line buffers are not reset.
  - Reset mid-frame discards the partial frame; the stream resumes as a new frame at (0,0).

## Timing
- Latency: a window appears on `out_valid` on the clock edge that accepts its bottom-right pixel, i.e. it is visible the cycle after `in_valid`.
- Throughput: 1 window/cycle when `out_ready` is held high.
- Stall: with `out_valid=1` and `out_ready=0`, `in_ready=0`, and nothing in the block changes.
- Line-buffer read is asynchronous (distributed RAM). Read-before-write within the same cycle is required.

## Configuration
- `WIN3_FRAME_MARKERS_EN` defined:
  - Adds outputs `out_sof` and `out_eol`, registered with the window.
  - `out_sof`=1 for the first window of a frame (row 2, col 2).
  - `out_eol`=1 for the last window of a row (col IMAGE_WIDTH−1).
  - Both reset to 0.
- Undefined: these ports and their logic are absent; everything else is identical.

## Structure
- Additions to `definitions_pkg`:
  - `WIN_K = 3`.
  - `typedef logic [7:0] pixel_t`.
  - `typedef pixel_t [0:8] window_t`, indexed like the kernels.
- Sub-module `line_buffer`: parameterised depth and width, asynchronous read and synchronous write at a single address. Instantiated twice.

## Test plan
Unless noted, IMAGE_WIDTH=8 and pixel = (row·8 + col) & 0xFF.
- Reset, then stream 24 pixels with `in_sof` on the first and `out_ready`=1 → first window after the pixel with value 18, equal to {0,1,2,8,9,10,16,17,18}. Exactly 6 windows for row 2; the last is {5,6,7,13,14,15,21,22,23}.
- Hold `out_ready`=0 for 5 cycles while a window is pending → `in_ready`=0 and `out_window` is unchanged. On release, the stream continues with no lost or duplicated windows.
- Assert `in_sof` at (row 2, col 4) of a frame → no window is emitted until the new frame's pixel (2,2). The first window contains only new-frame data.
- Assert `rst` mid-row 3 → `out_valid`=0 immediately (asynchronous). Restart the stream → windows match a clean run.
- Random `in_valid`/`out_ready` over a 10×8 frame → 48 windows, each matching the reference model.
- With `WIN3_FRAME_MARKERS_EN`: `out_sof` only on window {0,1,2,8,9,10,16,17,18}, and `out_eol` on every window whose element 8 has col 7.
